// File: rtl/branch_pair_packer_pkg.sv
// Shared widths, vector types and beat packing helpers for the branch pair packer.
package blk_pkg;

  localparam int LANES  = 9;
  localparam int DW     = 32;
  localparam int VEC_W  = LANES * DW;
  localparam int PAIR_W = 2 * VEC_W;
  localparam int BEAT_W = VEC_W + 1;

  typedef logic [VEC_W-1:0]  lane_vec_t;
  typedef logic [PAIR_W-1:0] pair_vec_t;

  typedef struct packed {
    logic      last;
    lane_vec_t data;
  } beat_t;

  function automatic beat_t make_beat(input logic last, input lane_vec_t data);
    beat_t b;
    b.last = last;
    b.data = data;
    return b;
  endfunction

endpackage

// File: rtl/branch_pair_packer_fifo.sv
// Small per-branch FIFO with wrap-bit pointers; head is the oldest entry, valid when !empty.
module branch_fifo #(
  parameter int W     = 289,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_pair_packer.sv
// Pairs branch A (low half) and branch B (high half) beats into one registered output word.
// Optional build macro PAIR_CNT_EN adds a per-tile handshake counter on pair_cnt.
module branch_pair_packer
  import blk_pkg::*;
#(
  parameter int LANES = blk_pkg::LANES,
  parameter int DW    = blk_pkg::DW,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [LANES*DW-1:0]     a_data,
  input  logic                    a_last,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [LANES*DW-1:0]     b_data,
  input  logic                    b_last,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [2*LANES*DW-1:0]   o_data,
  output logic                    o_last,
`ifdef PAIR_CNT_EN
  output logic [31:0]             pair_cnt,
`endif
  output logic                    err_align
);

  localparam int VW = LANES * DW;

  logic          a_full, a_empty, b_full, b_empty;
  logic [VW:0]   a_head, b_head;
  logic          a_push, b_push;
  logic          pair;
  logic          handshake;

  assign a_ready   = !a_full;
  assign b_ready   = !b_full;
  assign a_push    = a_valid && a_ready;
  assign b_push    = b_valid && b_ready;
  assign pair      = !a_empty && !b_empty && (!o_valid || o_ready);
  assign handshake = o_valid && o_ready;

  branch_fifo #(.W(VW + 1), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_push),
    .pop   (pair),
    .din   ({a_last, a_data}),
    .full  (a_full),
    .empty (a_empty),
    .head  (a_head)
  );

  branch_fifo #(.W(VW + 1), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .pop   (pair),
    .din   ({b_last, b_data}),
    .full  (b_full),
    .empty (b_empty),
    .head  (b_head)
  );

  // A pair can load while the previous word is being taken, giving one word per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (pair) begin
      o_valid <= 1'b1;
      o_data  <= {b_head[VW-1:0], a_head[VW-1:0]};
      o_last  <= a_head[VW];
    end else if (handshake) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_align <= 1'b0;
    end else if (pair && (a_head[VW] != b_head[VW])) begin
      err_align <= 1'b1;
    end
  end

`ifdef PAIR_CNT_EN
  logic        cnt_clr_pend;
  logic [31:0] cnt_base;

  // The final count of a tile stays visible for one cycle before clearing.
  assign cnt_base = cnt_clr_pend ? 32'd0 : pair_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt     <= '0;
      cnt_clr_pend <= 1'b0;
    end else begin
      pair_cnt     <= cnt_base + {31'd0, handshake};
      cnt_clr_pend <= handshake && o_last;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pair_packer.sv
// Directed self-checking bench for branch_pair_packer: pairing, skew, backpressure, tile-end mismatch, reset.
module tb_branch_pair_packer;
  import blk_pkg::*;

  localparam int VW = LANES * DW;
  localparam int PW = 2 * VW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_last, b_valid, b_last;
  logic          a_ready, b_ready;
  logic [VW-1:0] a_data, b_data;
  logic          o_valid, o_ready, o_last, err_align;
  logic [PW-1:0] o_data;
`ifdef PAIR_CNT_EN
  logic [31:0]   pair_cnt;
`endif

  int passed = 0;
  int total  = 0;
  int na, nb;

  always #5 clk = ~clk;

  branch_pair_packer dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .a_last    (a_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .b_last    (b_last),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_last    (o_last),
`ifdef PAIR_CNT_EN
    .pair_cnt  (pair_cnt),
`endif
    .err_align (err_align)
  );

  function automatic lane_vec_t vec(input int base);
    lane_vec_t v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 32'(base + i);
    return v;
  endfunction

  function automatic pair_vec_t pv(input int abase, input int bbase);
    return {vec(bbase), vec(abase)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
    a_data = '0; b_data = '0; o_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_o_valid", PW'(o_valid), 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_last", PW'(o_last), 0);
    check("rst_err", PW'(err_align), 0);
    check("rst_a_ready", PW'(a_ready), 1);
    check("rst_b_ready", PW'(b_ready), 1);

    // single pair
    a_valid = 1; a_data = vec(1);
    step();
    a_valid = 0;
    check("single_no_b", PW'(o_valid), 0);
    b_valid = 1; b_data = vec('h100);
    step();
    b_valid = 0;
    check("single_push_edge", PW'(o_valid), 0);
    step();
    check("single_valid", PW'(o_valid), 1);
    check("single_data", o_data, pv(1, 'h100));
    check("single_last", PW'(o_last), 0);
    step();
    check("single_drain", PW'(o_valid), 0);

    // skew: A fills alone, then B streams in
    for (int k = 0; k < 4; k++) begin
      a_valid = 1; a_data = vec('h10 + k * 'h10);
      step();
    end
    a_valid = 0;
    check("skew_a_full", PW'(a_ready), 0);
    check("skew_no_out", PW'(o_valid), 0);
    b_valid = 1; b_data = vec('h500);
    step();
    check("skew_b0_edge", PW'(o_valid), 0);
    for (int k = 1; k < 4; k++) begin
      b_data = vec('h500 + k * 'h10);
      step();
      check($sformatf("skew_pair%0d", k - 1), o_data, pv('h10 + (k - 1) * 'h10, 'h500 + (k - 1) * 'h10));
      check($sformatf("skew_valid%0d", k - 1), PW'(o_valid), 1);
    end
    b_valid = 0;
    step();
    check("skew_pair3", o_data, pv('h40, 'h530));
    step();
    check("skew_drain", PW'(o_valid), 0);
    check("skew_a_ready", PW'(a_ready), 1);

    // backpressure: six stalled cycles, then release
    o_ready = 0; na = 0; nb = 0;
    a_valid = 1; b_valid = 1;
    for (int c = 1; c <= 6; c++) begin
      logic acc_a, acc_b;
      a_data = vec('h1000 + na * 'h10);
      b_data = vec('h2000 + nb * 'h10);
      acc_a = a_ready; acc_b = b_ready;
      step();
      if (acc_a) na++;
      if (acc_b) nb++;
      if (c >= 2) check($sformatf("bp_hold%0d", c), o_data, pv('h1000, 'h2000));
      if (c >= 5) begin
        check($sformatf("bp_a_ready%0d", c), PW'(a_ready), 0);
        check($sformatf("bp_b_ready%0d", c), PW'(b_ready), 0);
      end
    end
    a_valid = 0; b_valid = 0;
    check("bp_accepted_a", PW'(na), 5);
    check("bp_accepted_b", PW'(nb), 5);
    o_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("bp_rel%0d", k), o_data, pv('h1000 + k * 'h10, 'h2000 + k * 'h10));
      check($sformatf("bp_rel_valid%0d", k), PW'(o_valid), 1);
    end
    step();
    check("bp_drain", PW'(o_valid), 0);
    check("bp_ready_back", PW'(a_ready & b_ready), 1);

    // tile-end mismatch on the third pair
    a_valid = 1; b_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a_data = vec('h3000 + k * 'h10); b_data = vec('h4000 + k * 'h10);
      a_last = (k == 2); b_last = 0;
      step();
      if (k == 2) check("err_before", PW'(err_align), 0);
    end
    a_valid = 0; b_valid = 0; a_last = 0;
    step();
    check("err_word", o_data, pv('h3020, 'h4020));
    check("err_o_last", PW'(o_last), 1);
    check("err_rise", PW'(err_align), 1);
    step(); step();
    check("err_sticky", PW'(err_align), 1);
    check("err_drain", PW'(o_valid), 0);

    // reset with two entries queued and a held word
    o_ready = 0; a_valid = 1; b_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a_data = vec('h5000 + k * 'h10); b_data = vec('h6000 + k * 'h10);
      step();
    end
    a_valid = 0; b_valid = 0;
    check("mid_valid", PW'(o_valid), 1);
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_valid", PW'(o_valid), 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_ready", PW'(a_ready & b_ready), 1);
    check("mid_rst_err", PW'(err_align), 0);
    o_ready = 1; a_valid = 1; b_valid = 1;
    a_data = vec('h7000); b_data = vec('h8000);
    step();
    a_valid = 0; b_valid = 0;
    step();
    check("post_rst_data", o_data, pv('h7000, 'h8000));
    check("post_rst_valid", PW'(o_valid), 1);
    step();
    check("post_rst_no_stale", PW'(o_valid), 0);

`ifdef PAIR_CNT_EN
    rst = 1; step(); rst = 0;
    a_valid = 1; b_valid = 1;
    for (int k = 0; k < 5; k++) begin
      a_data = vec('h9000 + k); b_data = vec('hA000 + k);
      a_last = (k == 4); b_last = (k == 4);
      step();
    end
    a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
    step(); step();
    check("cnt_five", PW'(pair_cnt), 5);
    step();
    check("cnt_clear", PW'(pair_cnt), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
